// File: rtl/tl_ul_sram_responder.sv
// TileLink-UL responder backed by a byte-writable word SRAM.
// One request in flight; illegal requests get a denied response instead of a write/read.
module tl_ul_sram_responder #(
  parameter int ADDR_W   = 15,
  parameter int DEPTH    = 512,
  parameter int SOURCE_W = 2
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [2:0]          a_opcode,
  input  logic [3:0]          a_size,
  input  logic [SOURCE_W-1:0] a_source,
  input  logic [ADDR_W-1:0]   a_address,
  input  logic [7:0]          a_mask,
  input  logic [63:0]         a_data,
  input  logic                a_corrupt,
  output logic                d_valid,
  input  logic                d_ready,
  output logic [2:0]          d_opcode,
  output logic [3:0]          d_size,
  output logic [SOURCE_W-1:0] d_source,
  output logic                d_denied,
  output logic [63:0]         d_data,
  output logic                d_corrupt
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int WORD_W = ADDR_W - 3;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e                state_q, state_d;
  logic [2:0]            op_q, op_d;
  logic [3:0]            size_q, size_d;
  logic [SOURCE_W-1:0]   src_q, src_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [7:0]            mask_q, mask_d;
  logic [63:0]           data_q, data_d;
  logic                  corrupt_q, corrupt_d;

  logic [2:0]            d_opcode_q, d_opcode_d;
  logic [3:0]            d_size_q, d_size_d;
  logic [SOURCE_W-1:0]   d_source_q, d_source_d;
  logic                  d_denied_q, d_denied_d;
  logic [63:0]           d_data_q, d_data_d;
  logic                  d_corrupt_q, d_corrupt_d;

  logic [63:0]           mem [DEPTH];
  logic [WORD_W-1:0]     word_idx;
  logic [63:0]           rd_word;
  logic [7:0]            lane_base, lane_mask;
  logic [ADDR_W-1:0]     align_bits;
  logic                  is_put_full, is_put_part, is_put, is_get;
  logic                  align_ok, range_ok, mask_ok, legal;
  logic                  mem_we;

  assign word_idx = addr_q[ADDR_W-1:3];
  assign rd_word  = mem[word_idx[IDX_W-1:0]];

  // Legality is evaluated on the captured request during ACCESS.
  always_comb begin
    is_put_full = (op_q == 3'd0);
    is_put_part = (op_q == 3'd1);
    is_get      = (op_q == 3'd4);
    is_put      = is_put_full | is_put_part;
    case (size_q[1:0])
      2'd0:    lane_base = 8'h01;
      2'd1:    lane_base = 8'h03;
      2'd2:    lane_base = 8'h0f;
      default: lane_base = 8'hff;
    endcase
    lane_mask  = lane_base << addr_q[2:0];
    align_bits = ~({ADDR_W{1'b1}} << size_q);
    align_ok   = ((addr_q & align_bits) == '0);
    range_ok   = (32'(word_idx) < 32'(DEPTH));
    if (is_put_part) mask_ok = (mask_q != 8'h00) && ((mask_q & ~lane_mask) == 8'h00);
    else             mask_ok = (mask_q == lane_mask);
    legal = (is_put | is_get) & (size_q <= 4'd3) & align_ok & range_ok & mask_ok
            & ~(is_put & corrupt_q);
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    size_d      = size_q;
    src_d       = src_q;
    addr_d      = addr_q;
    mask_d      = mask_q;
    data_d      = data_q;
    corrupt_d   = corrupt_q;
    d_opcode_d  = d_opcode_q;
    d_size_d    = d_size_q;
    d_source_d  = d_source_q;
    d_denied_d  = d_denied_q;
    d_data_d    = d_data_q;
    d_corrupt_d = d_corrupt_q;
    mem_we      = 1'b0;
    case (state_q)
      IDLE: begin
        if (a_valid) begin
          op_d      = a_opcode;
          size_d    = a_size;
          src_d     = a_source;
          addr_d    = a_address;
          mask_d    = a_mask;
          data_d    = a_data;
          corrupt_d = a_corrupt;
          state_d   = ACCESS;
        end
      end
      ACCESS: begin
        d_opcode_d  = is_get ? 3'd1 : 3'd0;
        d_size_d    = size_q;
        d_source_d  = src_q;
        d_denied_d  = ~legal;
        d_corrupt_d = is_get & ~legal;
        d_data_d    = (legal & is_get) ? rd_word : 64'h0;
        mem_we      = legal & is_put;
        state_d     = RESP;
      end
      RESP: begin
        if (d_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      d_opcode_q  <= 3'd0;
      d_size_q    <= 4'd0;
      d_source_q  <= '0;
      d_denied_q  <= 1'b0;
      d_data_q    <= 64'h0;
      d_corrupt_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      d_opcode_q  <= d_opcode_d;
      d_size_q    <= d_size_d;
      d_source_q  <= d_source_d;
      d_denied_q  <= d_denied_d;
      d_data_q    <= d_data_d;
      d_corrupt_q <= d_corrupt_d;
    end
  end

  always_ff @(posedge clock) begin
    op_q      <= op_d;
    size_q    <= size_d;
    src_q     <= src_d;
    addr_q    <= addr_d;
    mask_q    <= mask_d;
    data_q    <= data_d;
    corrupt_q <= corrupt_d;
  end

  // Reset on the ACCESS edge cancels the pending write.
  always_ff @(posedge clock) begin
    if (reset_n && mem_we) begin
      for (int i = 0; i < 8; i++) begin
        if (mask_q[i]) mem[word_idx[IDX_W-1:0]][8*i +: 8] <= data_q[8*i +: 8];
      end
    end
  end

  assign a_ready   = (state_q == IDLE) & reset_n;
  assign d_valid   = (state_q == RESP);
  assign d_opcode  = d_opcode_q;
  assign d_size    = d_size_q;
  assign d_source  = d_source_q;
  assign d_denied  = d_denied_q;
  assign d_data    = d_data_q;
  assign d_corrupt = d_corrupt_q;

endmodule

// File: tb/tb_tl_ul_sram_responder.sv
// Directed bench for tl_ul_sram_responder: vector table plus backpressure/reset sequences.
module tb_tl_ul_sram_responder;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        a_valid;
  logic        a_ready;
  logic [2:0]  a_opcode;
  logic [3:0]  a_size;
  logic [1:0]  a_source;
  logic [14:0] a_address;
  logic [7:0]  a_mask;
  logic [63:0] a_data;
  logic        a_corrupt;
  logic        d_valid;
  logic        d_ready;
  logic [2:0]  d_opcode;
  logic [3:0]  d_size;
  logic [1:0]  d_source;
  logic        d_denied;
  logic [63:0] d_data;
  logic        d_corrupt;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  tl_ul_sram_responder dut (
    .clock(clock), .reset_n(reset_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_size(a_size),
    .a_source(a_source), .a_address(a_address), .a_mask(a_mask), .a_data(a_data),
    .a_corrupt(a_corrupt),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_size(d_size),
    .d_source(d_source), .d_denied(d_denied), .d_data(d_data), .d_corrupt(d_corrupt)
  );

  typedef struct {
    logic [2:0]  op;
    logic [3:0]  size;
    logic [1:0]  src;
    logic [14:0] addr;
    logic [7:0]  mask;
    logic [63:0] data;
    logic        cor;
    logic [2:0]  e_op;
    logic        e_den;
    logic        e_cor;
    logic [63:0] e_data;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [2:0] op, input logic [3:0] size, input logic [1:0] src,
                              input logic [14:0] addr, input logic [7:0] mask, input logic [63:0] data,
                              input logic cor, input logic [2:0] e_op, input logic e_den,
                              input logic e_cor, input logic [63:0] e_data);
    vec_t v;
    v.op = op; v.size = size; v.src = src; v.addr = addr; v.mask = mask; v.data = data;
    v.cor = cor; v.e_op = e_op; v.e_den = e_den; v.e_cor = e_cor; v.e_data = e_data;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    a_opcode  = v.op;
    a_size    = v.size;
    a_source  = v.src;
    a_address = v.addr;
    a_mask    = v.mask;
    a_data    = v.data;
    a_corrupt = v.cor;
  endtask

  task automatic chk_resp(input string tag, input vec_t v);
    chk($sformatf("%s.d_valid", tag),   64'(d_valid),   64'(1));
    chk($sformatf("%s.d_opcode", tag),  64'(d_opcode),  64'(v.e_op));
    chk($sformatf("%s.d_size", tag),    64'(d_size),    64'(v.size));
    chk($sformatf("%s.d_source", tag),  64'(d_source),  64'(v.src));
    chk($sformatf("%s.d_denied", tag),  64'(d_denied),  64'(v.e_den));
    chk($sformatf("%s.d_corrupt", tag), 64'(d_corrupt), 64'(v.e_cor));
    chk($sformatf("%s.d_data", tag),    d_data,         v.e_data);
  endtask

  // Called #1 after an edge with d_ready=1; D must be valid two edges after the A fire.
  task automatic run_req(input vec_t v, input string tag);
    int w = 0;
    while (a_ready !== 1'b1 && w < 10) begin
      @(posedge clock); #1; w++;
    end
    chk($sformatf("%s.a_ready_idle", tag), 64'(a_ready), 64'(1));
    drive(v);
    a_valid = 1'b1;
    @(posedge clock); #1;
    a_valid = 1'b0;
    chk($sformatf("%s.access_d_valid", tag), 64'(d_valid), 64'(0));
    chk($sformatf("%s.access_a_ready", tag), 64'(a_ready), 64'(0));
    @(posedge clock); #1;
    chk_resp(tag, v);
    @(posedge clock); #1;
    chk($sformatf("%s.after_d_valid", tag), 64'(d_valid), 64'(0));
    chk($sformatf("%s.after_a_ready", tag), 64'(a_ready), 64'(1));
  endtask

  initial begin
    vec_t v;
    reset_n = 1'b0; a_valid = 1'b0; d_ready = 1'b1;
    drive(mk(3'd0, 4'd0, 2'd0, 15'h0, 8'h0, 64'h0, 1'b0, 3'd0, 1'b0, 1'b0, 64'h0));

    //          op    size  src   addr       mask   data                    cor  eop   den  cor  edata
    vecs.push_back(mk(3'd0, 4'd3, 2'd1, 15'h0010, 8'hff, 64'h1122334455667788, 1'b0, 3'd0, 1'b0, 1'b0, 64'h0));
    vecs.push_back(mk(3'd4, 4'd3, 2'd2, 15'h0010, 8'hff, 64'h0,                1'b0, 3'd1, 1'b0, 1'b0, 64'h1122334455667788));
    vecs.push_back(mk(3'd1, 4'd3, 2'd3, 15'h0010, 8'h0f, 64'hAAAAAAAABBBBBBBB, 1'b0, 3'd0, 1'b0, 1'b0, 64'h0));
    vecs.push_back(mk(3'd4, 4'd3, 2'd0, 15'h0010, 8'hff, 64'h0,                1'b0, 3'd1, 1'b0, 1'b0, 64'h11223344BBBBBBBB));
    vecs.push_back(mk(3'd4, 4'd2, 2'd1, 15'h0012, 8'h3c, 64'h0,                1'b0, 3'd1, 1'b1, 1'b1, 64'h0));
    vecs.push_back(mk(3'd0, 4'd2, 2'd2, 15'h0014, 8'h0f, 64'hFFFFFFFFFFFFFFFF, 1'b0, 3'd0, 1'b1, 1'b0, 64'h0));
    vecs.push_back(mk(3'd0, 4'd3, 2'd3, 15'h0010, 8'hff, 64'h0,                1'b1, 3'd0, 1'b1, 1'b0, 64'h0));
    vecs.push_back(mk(3'd4, 4'd3, 2'd0, 15'h0010, 8'hff, 64'h0,                1'b0, 3'd1, 1'b0, 1'b0, 64'h11223344BBBBBBBB));
    vecs.push_back(mk(3'd0, 4'd2, 2'd1, 15'h0014, 8'hf0, 64'hDEADBEEF00000000, 1'b0, 3'd0, 1'b0, 1'b0, 64'h0));
    vecs.push_back(mk(3'd1, 4'd0, 2'd2, 15'h0011, 8'h02, 64'h0000000000005500, 1'b0, 3'd0, 1'b0, 1'b0, 64'h0));
    vecs.push_back(mk(3'd1, 4'd1, 2'd3, 15'h0016, 8'hc0, 64'h1234000000000000, 1'b0, 3'd0, 1'b0, 1'b0, 64'h0));
    vecs.push_back(mk(3'd4, 4'd2, 2'd0, 15'h0014, 8'hf0, 64'h0,                1'b0, 3'd1, 1'b0, 1'b0, 64'h1234BEEFBBBB55BB));
    vecs.push_back(mk(3'd4, 4'd3, 2'd1, 15'h1000, 8'hff, 64'h0,                1'b0, 3'd1, 1'b1, 1'b1, 64'h0));
    vecs.push_back(mk(3'd0, 4'd3, 2'd2, 15'h0FF8, 8'hff, 64'hCAFEF00D12345678, 1'b0, 3'd0, 1'b0, 1'b0, 64'h0));
    vecs.push_back(mk(3'd4, 4'd3, 2'd3, 15'h0FF8, 8'hff, 64'h0,                1'b0, 3'd1, 1'b0, 1'b0, 64'hCAFEF00D12345678));
    vecs.push_back(mk(3'd1, 4'd3, 2'd3, 15'h0010, 8'h00, 64'hFFFFFFFFFFFFFFFF, 1'b0, 3'd0, 1'b1, 1'b0, 64'h0));
    vecs.push_back(mk(3'd4, 4'd4, 2'd0, 15'h0010, 8'hff, 64'h0,                1'b0, 3'd1, 1'b1, 1'b1, 64'h0));
    vecs.push_back(mk(3'd4, 4'd3, 2'd1, 15'h0010, 8'h0f, 64'h0,                1'b0, 3'd1, 1'b1, 1'b1, 64'h0));
    vecs.push_back(mk(3'd1, 4'd2, 2'd2, 15'h0010, 8'h1f, 64'hFFFFFFFFFFFFFFFF, 1'b0, 3'd0, 1'b1, 1'b0, 64'h0));
    vecs.push_back(mk(3'd4, 4'd3, 2'd3, 15'h0010, 8'hff, 64'h0,                1'b0, 3'd1, 1'b0, 1'b0, 64'h1234BEEFBBBB55BB));
    vecs.push_back(mk(3'd7, 4'd3, 2'd0, 15'h0010, 8'hff, 64'h0,                1'b0, 3'd0, 1'b1, 1'b0, 64'h0));

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    chk("rst.a_ready",   64'(a_ready),   64'(0));
    chk("rst.d_valid",   64'(d_valid),   64'(0));
    chk("rst.d_opcode",  64'(d_opcode),  64'(0));
    chk("rst.d_size",    64'(d_size),    64'(0));
    chk("rst.d_source",  64'(d_source),  64'(0));
    chk("rst.d_denied",  64'(d_denied),  64'(0));
    chk("rst.d_data",    d_data,         64'h0);
    chk("rst.d_corrupt", 64'(d_corrupt), 64'(0));
    reset_n = 1'b1;
    @(posedge clock); #1;

    for (int i = 0; i < vecs.size(); i++) run_req(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: response held 5 cycles, queued Get accepted one cycle after D fires
    d_ready = 1'b0;
    v = mk(3'd0, 4'd3, 2'd2, 15'h0018, 8'hff, 64'h0102030405060708, 1'b0, 3'd0, 1'b0, 1'b0, 64'h0);
    drive(v);
    a_valid = 1'b1;
    @(posedge clock); #1;
    v = mk(3'd4, 4'd3, 2'd1, 15'h0018, 8'hff, 64'h0, 1'b0, 3'd1, 1'b0, 1'b0, 64'h0102030405060708);
    drive(v);
    @(posedge clock); #1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp%0d.d_valid", k),  64'(d_valid),  64'(1));
      chk($sformatf("bp%0d.d_opcode", k), 64'(d_opcode), 64'(0));
      chk($sformatf("bp%0d.d_denied", k), 64'(d_denied), 64'(0));
      chk($sformatf("bp%0d.d_size", k),   64'(d_size),   64'(3));
      chk($sformatf("bp%0d.d_source", k), 64'(d_source), 64'(2));
      chk($sformatf("bp%0d.d_data", k),   d_data,        64'h0);
      chk($sformatf("bp%0d.a_ready", k),  64'(a_ready),  64'(0));
      @(posedge clock); #1;
    end
    d_ready = 1'b1;
    @(posedge clock); #1;
    chk("bp.fire_d_valid", 64'(d_valid), 64'(0));
    chk("bp.fire_a_ready", 64'(a_ready), 64'(1));
    @(posedge clock); #1;
    a_valid = 1'b0;
    chk("bp.get_access_d_valid", 64'(d_valid), 64'(0));
    chk("bp.get_access_a_ready", 64'(a_ready), 64'(0));
    @(posedge clock); #1;
    chk_resp("bp.get", v);
    @(posedge clock); #1;
    chk("bp.done_d_valid", 64'(d_valid), 64'(0));

    // Reset during RESP drops the response
    d_ready = 1'b0;
    drive(mk(3'd4, 4'd3, 2'd3, 15'h0010, 8'hff, 64'h0, 1'b0, 3'd1, 1'b0, 1'b0, 64'h0));
    a_valid = 1'b1;
    @(posedge clock); #1;
    a_valid = 1'b0;
    @(posedge clock); #1;
    chk("rr.d_valid_before", 64'(d_valid), 64'(1));
    reset_n = 1'b0;
    #1;
    chk("rr.a_ready_in_reset", 64'(a_ready), 64'(0));
    @(posedge clock); #1;
    chk("rr.d_valid",  64'(d_valid),  64'(0));
    chk("rr.d_data",   d_data,        64'h0);
    chk("rr.d_opcode", 64'(d_opcode), 64'(0));
    chk("rr.d_source", 64'(d_source), 64'(0));
    reset_n = 1'b1;
    d_ready = 1'b1;
    #1;
    chk("rr.a_ready_after", 64'(a_ready), 64'(1));
    @(posedge clock); #1;
    run_req(mk(3'd2, 4'd3, 2'd1, 15'h0010, 8'hff, 64'h0, 1'b0, 3'd0, 1'b1, 1'b0, 64'h0), "rr.op2");

    // Reset on the ACCESS edge cancels the write
    run_req(mk(3'd0, 4'd3, 2'd0, 15'h0020, 8'hff, 64'hA5A5A5A5A5A5A5A5, 1'b0, 3'd0, 1'b0, 1'b0, 64'h0), "ra.init");
    drive(mk(3'd0, 4'd3, 2'd0, 15'h0020, 8'hff, 64'h5A5A5A5A5A5A5A5A, 1'b0, 3'd0, 1'b0, 1'b0, 64'h0));
    a_valid = 1'b1;
    @(posedge clock); #1;
    a_valid = 1'b0;
    reset_n = 1'b0;
    @(posedge clock); #1;
    chk("ra.d_valid", 64'(d_valid), 64'(0));
    reset_n = 1'b1;
    #1;
    run_req(mk(3'd4, 4'd3, 2'd1, 15'h0020, 8'hff, 64'h0, 1'b0, 3'd1, 1'b0, 1'b0, 64'hA5A5A5A5A5A5A5A5), "ra.get");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
